cache_set_assoc: RTL

CACHE_SET_ASSOC -- requirements
Module: cache_set_assoc

---
 rtl/cache_set_assoc.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_set_assoc.sv
// Set-associative write-back / write-allocate cache with true-LRU ages.
// Misses run a line write-back (dirty victim) and a line refill over a word-wide handshake.
module cache_set_assoc #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] WD,
    input  logic              WE,
    input  logic              RE,
    output logic [DATA_W-1:0] RD,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rd,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    // state  | meaning
    // IDLE   | combinational lookup; hits complete here
    // WBACK  | writing the dirty victim line to memory
    // REFILL | reading the requested line into the victim way

    localparam int LOG_OFF   = $clog2(LINE_WORDS);
    localparam int LOG_SET   = $clog2(SETS);
    localparam int LOG_WAY   = $clog2(WAYS);
    localparam int OFF_W     = (LOG_OFF > 0) ? LOG_OFF : 1;
    localparam int IDX_W     = (LOG_SET > 0) ? LOG_SET : 1;
    localparam int WAY_W     = (LOG_WAY > 0) ? LOG_WAY : 1;
    localparam int IDX_SHIFT = 2 + LOG_OFF;
    localparam int TAG_SHIFT = IDX_SHIFT + LOG_SET;
    localparam int TAG_W     = ADDR_W - TAG_SHIFT;

    localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(LINE_WORDS - 1);
    localparam logic [WAY_W-1:0]  OLDEST    = WAY_W'(WAYS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] IDX_MASK  = ADDR_W'(SETS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBACK  = 2'd1,
        REFILL = 2'd2
    } state_t;

    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS][LINE_WORDS];

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [WAY_W-1:0]  victim_q;
    logic              retry_q;
    logic [15:0]       hit_cnt_q, miss_cnt_q;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              have_free;
    logic [WAY_W-1:0]  free_way;
    logic [WAY_W-1:0]  old_way;
    logic [WAY_W-1:0]  victim;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0] t,
                                                    input logic [IDX_W-1:0] i,
                                                    input logic [OFF_W-1:0] o);
        return (ADDR_W'(t) << TAG_SHIFT)
             | ((ADDR_W'(i) & IDX_MASK) << IDX_SHIFT)
             | ((ADDR_W'(o) & OFF_MASK) << 2);
    endfunction

    always_comb begin
        req_off = OFF_W'((A >> 2) & OFF_MASK);
        req_idx = IDX_W'((A >> IDX_SHIFT) & IDX_MASK);
        req_tag = TAG_W'(A >> TAG_SHIFT);
        req     = WE | RE;
    end

    // Victim choice: lowest-index invalid way first, otherwise the oldest way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        have_free = 1'b0;
        free_way  = '0;
        old_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w] && !have_free) begin
                have_free = 1'b1;
                free_way  = WAY_W'(w);
            end
            if (age_q[req_idx][w] == OLDEST) begin
                old_way = WAY_W'(w);
            end
        end
        victim = have_free ? free_way : old_way;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        RD       = '0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        done = 1'b1;
                        RD   = data_q[req_idx][hit_way][req_off];
                    end else begin
                        cnt_d   = '0;
                        state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim])
                                  ? WBACK : REFILL;
                    end
                end
            end
            WBACK: begin
                mem_we   = 1'b1;
                mem_addr = word_addr(tag_q[req_idx][victim_q], req_idx, cnt_q);
                mem_wd   = data_q[req_idx][victim_q][cnt_q];
                if (mem_ack) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = REFILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            REFILL: begin
                mem_re   = 1'b1;
                mem_addr = word_addr(req_tag, req_idx, cnt_q);
                if (mem_ack) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // retry_q marks the post-refill lookup so it completes without counting as a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            victim_q   <= '0;
            retry_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == IDLE) && req && !hit) begin
                victim_q <= victim;
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
            if (done) begin
                retry_q <= 1'b0;
                if (!retry_q && (hit_cnt_q != 16'hFFFF)) begin
                    hit_cnt_q <= hit_cnt_q + 16'd1;
                end
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age_q[req_idx][w] <= '0;
                    end else if (age_q[req_idx][w] < age_q[req_idx][hit_way]) begin
                        age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
                    end
                end
                if (WE) begin
                    dirty_q[req_idx][hit_way] <= 1'b1;
                end
            end
            if ((state_q == REFILL) && mem_ack && (cnt_q == LAST_WORD)) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
                tag_q[req_idx][victim_q]   <= req_tag;
                retry_q                    <= 1'b1;
            end
        end
    end

    // Line data needs no reset: every valid bit is cleared instead.
    always_ff @(posedge clk) begin
        if (done && WE) begin
            data_q[req_idx][hit_way][req_off] <= WD;
        end
        if ((state_q == REFILL) && mem_ack) begin
            data_q[req_idx][victim_q][cnt_q] <= mem_rd;
        end
    end

    assign busy     = (state_q != IDLE);
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule
